// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register plus req/ready instruction fetch with jump/branch/redirect next-PC selection.
// Optional FETCH_MISALIGN_CHECK_EN adds a one-cycle misalign pulse when a PC target had nonzero low bits.
module instr_fetch_unit #(
  parameter int IMEM_AW = 32,
  parameter logic [IMEM_AW-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic [5:0]         func,
  output logic [IMEM_AW-1:0] pc_out,
  input  logic               stall,
  input  logic               jump,
  input  logic               branch,
  input  logic               zero,
  input  logic               redirect,
  input  logic [IMEM_AW-1:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic               misalign
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d, pc4, npc, tgt;
  logic [31:0] instr_q, instr_d;
  logic valid_q, valid_d, consume, load_pc;
  assign pc4 = pc_q + IMEM_AW'(4);
  assign npc = jump ? {pc4[IMEM_AW-1:28], instr_q[25:0], 2'b00}
             : (branch & zero) ? pc4 + {{(IMEM_AW-18){instr_q[15]}}, instr_q[15:0], 2'b00}
             : pc4;
  assign consume = state_q == HOLD && !stall;
  assign load_pc = redirect || consume;
  // redirect outranks the consumer's own next-PC choice in every state
  assign tgt = redirect ? redirect_pc : npc;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (load_pc) begin
      pc_d = tgt & ~IMEM_AW'(3);
      valid_d = 1'b0;
      state_d = FETCH;
    end else if (state_q == IDLE) begin
      state_d = FETCH;
    end else if (state_q == FETCH && imem_ready) begin
      instr_d = imem_rdata;
      valid_d = 1'b1;
      state_d = HOLD;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end
`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else mis_q <= load_pc && |tgt[1:0];
  end
  assign misalign = mis_q;
`endif
  assign imem_req = state_q == FETCH;
  assign imem_addr = pc_q;
  assign pc_out = pc_q;
  assign instr_valid = valid_q;
  assign instr = instr_q;
  assign opcode = instr_q[31:26];
  assign func = instr_q[5:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed table of next-PC cases, hand-written corner sequences,
// and a randomized run compared against a transaction-level fetch model.
module tb_instr_fetch_unit;
  logic clk = 0, rst = 1;
  logic imem_req, instr_valid;
  logic imem_ready = 0, stall = 0, jump = 0, branch = 0, zero = 0, redirect = 0;
  logic [31:0] imem_addr, imem_rdata, instr, pc_out;
  logic [31:0] redirect_pc = '0;
  logic [5:0] opcode, func;
  logic ovr_en = 0;
  logic [31:0] ovr_word = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign;
  logic exp_mis;
`endif
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always_comb imem_rdata = ovr_en ? ovr_word : memw(imem_addr);

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr),
    .opcode(opcode), .func(func), .pc_out(pc_out),
    .stall(stall), .jump(jump), .branch(branch), .zero(zero),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic j, b, z;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] w,
                                            input logic j, input logic b, input logic z);
    logic [31:0] pc4;
    pc4 = pc + 4;
    if (j) return (pc4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b && z) return pc4 + (32'($signed(w[15:0])) << 2);
    return pc4;
  endfunction

  initial begin
    logic [31:0] held, exp_pc, exp_word, w;
    logic exp_valid, exp_req;
    vecs[0] = '{32'h1000_0000, 32'h0800_0010, 1'b1, 1'b0, 1'b0, 32'h1000_0040};
    vecs[1] = '{32'h0000_0020, 32'h1000_FFFF, 1'b0, 1'b1, 1'b1, 32'h0000_0020};
    vecs[2] = '{32'h0000_0020, 32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 32'h0000_0024};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[4] = '{32'h0000_0100, 32'h1000_0010, 1'b0, 1'b1, 1'b1, 32'h0000_0144};
    vecs[5] = '{32'h2000_0000, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 32'h2000_000C};
    vecs[6] = '{32'hF000_0000, 32'h03FF_FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC};
    vecs[7] = '{32'h0000_0000, 32'h1000_7FFF, 1'b0, 1'b1, 1'b1, 32'h0002_0000};

    #2;
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_opfunc", {20'd0, opcode, func}, 0);
    step;
    rst = 0;
    chk("idle_req", 32'(imem_req), 0);
    step;
    imem_ready = 1;
    for (int k = 0; k < 3; k++) begin
      chk("seq_req", 32'(imem_req), 1);
      chk("seq_addr", imem_addr, 32'(k * 4));
      chk("seq_valid_lo", 32'(instr_valid), 0);
      step;
      chk("seq_valid_hi", 32'(instr_valid), 1);
      chk("seq_req_lo", 32'(imem_req), 0);
      chk("seq_instr", instr, memw(32'(k * 4)));
      step;
    end

    step;
    imem_ready = 0;
    stall = 1;
    held = instr;
    for (int k = 0; k < 5; k++) begin
      step;
      chk("stall_instr", instr, held);
      chk("stall_pc", pc_out, 32'd12);
      chk("stall_req", 32'(imem_req), 0);
      chk("stall_valid", 32'(instr_valid), 1);
    end
    stall = 0;
    step;
    chk("stall_next_req", 32'(imem_req), 1);
    chk("stall_next_addr", imem_addr, 32'd16);

    for (int i = 0; i < 8; i++) begin
      redirect = 1;
      redirect_pc = vecs[i].pc;
      step;
      redirect = 0;
      ovr_en = 1;
      ovr_word = vecs[i].word;
      imem_ready = 1;
      step;
      imem_ready = 0;
      ovr_en = 0;
      chk("vec_instr", instr, vecs[i].word);
      chk("vec_opcode", 32'(opcode), 32'(vecs[i].word[31:26]));
      jump = vecs[i].j;
      branch = vecs[i].b;
      zero = vecs[i].z;
      step;
      jump = 0;
      branch = 0;
      zero = 0;
      chk("vec_req", 32'(imem_req), 1);
      chk("vec_next_addr", imem_addr, vecs[i].exp);
    end

    imem_ready = 1;
    redirect = 1;
    redirect_pc = 32'h100;
    step;
    redirect = 0;
    imem_ready = 0;
    chk("redir_drop_valid", 32'(instr_valid), 0);
    chk("redir_req", 32'(imem_req), 1);
    chk("redir_addr", imem_addr, 32'h100);
    step;
    chk("redir_still_invalid", 32'(instr_valid), 0);

    redirect = 1;
    redirect_pc = 32'h102;
    step;
    redirect = 0;
    chk("mis_addr", imem_addr, 32'h100);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_pulse", 32'(misalign), 1);
`endif
    step;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_clear", 32'(misalign), 0);
`endif

    #2 rst = 1;
    #1;
    chk("arst_req", 32'(imem_req), 0);
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_pc", pc_out, 0);
    chk("arst_instr", instr, 0);
    imem_ready = 1;
    step;
    rst = 0;
    chk("arst_late_ready", 32'(instr_valid), 0);
    chk("arst_idle_req", 32'(imem_req), 0);
    imem_ready = 0;
    step;
    chk("arst_restart_req", 32'(imem_req), 1);
    chk("arst_restart_addr", imem_addr, 0);

    redirect = 1;
    redirect_pc = 0;
    step;
    redirect = 0;
    exp_pc = 0;
    exp_word = 0;
    exp_valid = 0;
    exp_req = 1;
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_mis = 0;
`endif
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_valid", 32'(instr_valid), 32'(exp_valid));
      chk("rnd_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("rnd_addr", imem_addr, exp_pc);
      if (exp_valid) begin
        chk("rnd_instr", instr, exp_word);
        chk("rnd_pc_out", pc_out, exp_pc);
        chk("rnd_func", 32'(func), 32'(exp_word[5:0]));
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("rnd_misalign", 32'(misalign), 32'(exp_mis));
`endif
      imem_ready = $urandom_range(1);
      stall = $urandom_range(2) == 0;
      jump = $urandom_range(5) == 0;
      branch = $urandom_range(2) == 0;
      zero = $urandom_range(1);
      redirect = $urandom_range(9) == 0;
      redirect_pc = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
      exp_mis = redirect && redirect_pc[1:0] != 0;
`endif
      if (redirect) begin
        exp_pc = redirect_pc & ~32'd3;
        exp_valid = 0;
        exp_req = 1;
      end else if (exp_req && imem_ready) begin
        w = memw(exp_pc);
        exp_word = w;
        exp_valid = 1;
        exp_req = 0;
      end else if (exp_valid && !stall) begin
        exp_pc = model_npc(exp_pc, exp_word, jump, branch, zero) & ~32'd3;
        exp_valid = 0;
        exp_req = 1;
      end
      step;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
